// File: rtl/cnn_accel_pkg.sv
// Shared definitions for the CNN accelerator result path.
// Holds the default bus/data geometry, the result-reader state encoding
// and a helper for validating a run's element count.
package cnn_accel_pkg;

    localparam int BUS_ADDR_WIDTH = 32;
    localparam int BUS_DATA_WIDTH = 64;
    localparam int DATA_WIDTH     = 32;   // single-precision float element
    localparam int MAX_SIZE       = 4096; // elements per run

    // Result reader states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // A run must contain at least one element and fit in the result RAM.
    function automatic logic legalCount(input int unsigned n, input int unsigned maxSize);
        return (n >= 1) && (n <= maxSize);
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-clock result RAM with one write address and one read address.
// Ports: clkIn; wrEnIn/wrAddrIn/wrDataIn write port; rdEnIn/rdAddrIn read
// request; rdDataOut registered read data, one cycle after rdEnIn.
// A read and write to the same word in one cycle return the old contents.
// Contents are never reset.
module sp_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clkIn,
    input  logic             wrEnIn,
    input  logic [AW-1:0]    wrAddrIn,
    input  logic [WIDTH-1:0] wrDataIn,
    input  logic             rdEnIn,
    input  logic [AW-1:0]    rdAddrIn,
    output logic [WIDTH-1:0] rdDataOut
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both accesses use non-blocking updates, so a same-word collision
    // naturally reads the pre-write value.
    always_ff @(posedge clkIn) begin
        if (wrEnIn) mem[wrAddrIn] <= wrDataIn;
        if (rdEnIn) rdDataOut <= mem[rdAddrIn];
    end

endmodule

// File: rtl/cnn_result_reader.sv
// Collects result elements streamed from the accelerator output FIFO into a
// 64-bit result RAM (two elements per word) and serves CPU bus reads of it.
// Ports:
//   clkIn, rstIn                 clock, async active-high reset
//   startIn, numResultsIn        arm a run of numResultsIn elements
//   dataIn, validIn, readyOut    element stream handshake
//   addrIn, rdEnIn               bus read request (byte address)
//   rdDataOut, rdAckOut          bus read data, one cycle after request
//   busyOut, doneOut, errOut     collecting / run complete / illegal start
//   countOut                     elements accepted in the current/last run
module cnn_result_reader #(
    parameter int BUS_ADDR_WIDTH = cnn_accel_pkg::BUS_ADDR_WIDTH,
    parameter int BUS_DATA_WIDTH = cnn_accel_pkg::BUS_DATA_WIDTH,
    parameter int DATA_WIDTH     = cnn_accel_pkg::DATA_WIDTH,
    parameter int MAX_SIZE       = cnn_accel_pkg::MAX_SIZE,
    localparam int CNT_W         = $clog2(MAX_SIZE) + 1
) (
    input  logic                      clkIn,
    input  logic                      rstIn,
    input  logic                      startIn,
    input  logic [CNT_W-1:0]          numResultsIn,
    input  logic [DATA_WIDTH-1:0]     dataIn,
    input  logic                      validIn,
    output logic                      readyOut,
    input  logic [BUS_ADDR_WIDTH-1:0] addrIn,
    input  logic                      rdEnIn,
    output logic [BUS_DATA_WIDTH-1:0] rdDataOut,
    output logic                      rdAckOut,
    output logic                      busyOut,
    output logic                      doneOut,
    output logic                      errOut,
    output logic [CNT_W-1:0]          countOut
);
    import cnn_accel_pkg::*;

    localparam int WORDS  = MAX_SIZE / 2;
    localparam int WA_W   = $clog2(WORDS);
    localparam int IDX_HI = WA_W + 2;     // top bit of the word index in addrIn

    logic [1:0]                state;
    logic [CNT_W-1:0]          numResults;
    logic [DATA_WIDTH-1:0]     packReg;
    logic                      wrEn;
    logic                      wrLast;
    logic [WA_W-1:0]           wrAddr;
    logic [BUS_DATA_WIDTH-1:0] wrData;
    logic                      accept;
    logic                      lastElem;
    logic                      rdOor;
    logic                      oorQ;
    logic [BUS_DATA_WIDTH-1:0] ramQ;
    logic                      unusedAddrBits;

    assign accept   = validIn && readyOut;
    assign lastElem = (countOut == numResults - CNT_W'(1));
    assign busyOut  = (state == ST_COLLECT);
    assign doneOut  = (state == ST_DONE);

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state      <= ST_IDLE;
            readyOut   <= 1'b0;
            errOut     <= 1'b0;
            countOut   <= '0;
            numResults <= '0;
            packReg    <= '0;
            wrEn       <= 1'b0;
            wrLast     <= 1'b0;
            wrAddr     <= '0;
            wrData     <= '0;
        end else begin
            wrEn <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        countOut <= countOut + CNT_W'(1);
                        wrAddr   <= countOut[WA_W:1];
                        wrLast   <= lastElem;
                        if (!countOut[0]) begin
                            packReg <= dataIn;
                            // Odd-length run: flush the lone even element now.
                            if (lastElem) begin
                                wrEn   <= 1'b1;
                                wrData <= {{DATA_WIDTH{1'b0}}, dataIn};
                            end
                        end else begin
                            wrEn   <= 1'b1;
                            wrData <= {dataIn, packReg};
                        end
                        if (lastElem) readyOut <= 1'b0;
                    end
                    // The final word lands in RAM on this same edge.
                    if (wrEn && wrLast) state <= ST_DONE;
                end
                default: begin
                    if (startIn) begin
                        if (legalCount(32'(numResultsIn), MAX_SIZE)) begin
                            state      <= ST_COLLECT;
                            readyOut   <= 1'b1;
                            errOut     <= 1'b0;
                            countOut   <= '0;
                            numResults <= numResultsIn;
                            packReg    <= '0;
                            wrLast     <= 1'b0;
                        end else begin
                            errOut <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Bus read path: addresses with bits above the word index answer zero.
    assign rdOor          = |addrIn[BUS_ADDR_WIDTH-1:IDX_HI+1];
    assign unusedAddrBits = ^addrIn[2:0];

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            rdAckOut <= 1'b0;
            oorQ     <= 1'b0;
        end else begin
            rdAckOut <= rdEnIn;
            oorQ     <= rdOor;
        end
    end

    // RAM output is not reset, so the data bus is masked outside an ack.
    assign rdDataOut = (rdAckOut && !oorQ) ? ramQ : '0;

    sp_ram #(
        .DEPTH (WORDS),
        .WIDTH (BUS_DATA_WIDTH)
    ) uRam (
        .clkIn    (clkIn),
        .wrEnIn   (wrEn),
        .wrAddrIn (wrAddr),
        .wrDataIn (wrData),
        .rdEnIn   (rdEnIn),
        .rdAddrIn (addrIn[IDX_HI:3]),
        .rdDataOut(ramQ)
    );

endmodule

// File: tb/tb_cnn_result_reader.sv
// Scoreboard bench for cnn_result_reader: reads push expected words into a
// queue, a negedge monitor pops and compares on every rdAckOut. Expected RAM
// contents come from a word-level model built from each run's element list.
module tb_cnn_result_reader;

    localparam int CNT_W = 13;

    logic             clkIn = 1'b0;
    logic             rstIn, startIn, validIn, rdEnIn;
    logic             readyOut, rdAckOut, busyOut, doneOut, errOut;
    logic [CNT_W-1:0] numResultsIn, countOut;
    logic [31:0]      dataIn, addrIn;
    logic [63:0]      rdDataOut;

    cnn_result_reader dut (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .startIn     (startIn),
        .numResultsIn(numResultsIn),
        .dataIn      (dataIn),
        .validIn     (validIn),
        .readyOut    (readyOut),
        .addrIn      (addrIn),
        .rdEnIn      (rdEnIn),
        .rdDataOut   (rdDataOut),
        .rdAckOut    (rdAckOut),
        .busyOut     (busyOut),
        .doneOut     (doneOut),
        .errOut      (errOut),
        .countOut    (countOut)
    );

    always #5 clkIn = ~clkIn;

    int cyc = 0;
    always @(posedge clkIn) cyc <= cyc + 1;

    int nChecks = 0;
    int nPass   = 0;

    logic [63:0] expQ[$];
    string       nameQ[$];
    logic [63:0] mWord[int];   // model: word index -> expected contents

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: every ack must match the oldest outstanding read.
    always @(negedge clkIn) begin
        if (rdAckOut) begin
            if (expQ.size() == 0) begin
                nChecks++;
                $display("FAIL unexpectedAck: got ack with data 0x%0h, no read outstanding", rdDataOut);
            end else begin
                check(nameQ.pop_front(), rdDataOut, expQ.pop_front());
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic doRead(input logic [31:0] a, input logic [63:0] e, input string nm);
        rdEnIn = 1'b1;
        addrIn = a;
        expQ.push_back(e);
        nameQ.push_back(nm);
        @(posedge clkIn); #1;
        check({nm, "_ackLatency"}, rdAckOut, 1);
        rdEnIn = 1'b0;
        addrIn = $urandom;
    endtask

    task automatic startPulse(input int n);
        startIn      = 1'b1;
        numResultsIn = CNT_W'(n);
        @(posedge clkIn); #1;
        startIn = 1'b0;
    endtask

    task automatic checkResetOutputs(input string nm);
        check({nm, "_flags"}, {readyOut, busyOut, doneOut, errOut, rdAckOut}, 0);
        check({nm, "_count"}, countOut, 0);
        check({nm, "_rdData"}, rdDataOut, 0);
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps.
    task automatic runStream(input logic [31:0] el[$], input int mode, input bit hold,
                             input bit inject, input bit rdAtEnd);
        int k = 0, guard = 0, lastAcc = 0, par = 0;
        int n = el.size();
        bit drv, rdy, injected = 0;
        while (k < n && guard < 1000) begin
            case (mode)
                0:       drv = 1'b1;
                1:       drv = (par == 0);
                default: drv = ($urandom_range(0, 2) != 0);
            endcase
            par ^= 1;
            validIn = drv;
            dataIn  = drv ? el[k] : $urandom;
            if (inject && !injected && k == 1) begin
                startIn      = 1'b1;
                numResultsIn = CNT_W'(1);
                injected     = 1'b1;
            end
            rdy = readyOut;
            @(posedge clkIn); #1;
            startIn = 1'b0;
            if (drv && rdy) begin
                k++;
                lastAcc = cyc;
            end
            guard++;
        end
        check("allAccepted", k, n);
        validIn = hold;
        dataIn  = $urandom;
        check("readyLowAfterLast", readyOut, 0);
        if (rdAtEnd) doRead(32'h8, mWord[1], "readFirstWord1");
        guard = 0;
        while (!doneOut && guard < 50) begin
            @(posedge clkIn); #1;
            guard++;
        end
        check("doneLatency", cyc - lastAcc, 1);
        check("countOut", countOut, n);
        check("busyLowInDone", busyOut, 0);
        validIn = 1'b0;
        for (int j = 0; j < n; j += 2)
            mWord[j / 2] = {(j + 1 < n) ? el[j + 1] : 32'h0, el[j]};
    endtask

    task automatic readAll();
        foreach (mWord[w]) begin
            doRead(32'(w * 8) | 32'($urandom_range(0, 7)), mWord[w], "wordRead");
        end
        doRead(32'h1 << $urandom_range(14, 31), 64'h0, "oorRead");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] el[$];
        rstIn = 1'b1; startIn = 1'b0; validIn = 1'b0; rdEnIn = 1'b0;
        numResultsIn = '0; dataIn = '0; addrIn = '0;
        #12;
        checkResetOutputs("reset");
        @(posedge clkIn); #1;
        rstIn = 1'b0;

        // Illegal counts leave the block idle with a sticky error.
        startPulse(0);
        check("err_zero", {errOut, busyOut, doneOut, readyOut}, 4'b1000);
        startPulse(4097);
        check("err_over", {errOut, busyOut, doneOut, readyOut}, 4'b1000);

        // Four known floats streamed back-to-back.
        startPulse(4);
        check("legalStart", {errOut, busyOut, readyOut, countOut}, {3'b011, 13'd0});
        el = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        runStream(el, 0, 1'b0, 1'b0, 1'b0);
        doRead(32'h0, 64'h40000000_3F800000, "dir_word0");
        doRead(32'h8, 64'h40800000_40400000, "dir_word1");

        // Three elements with alternating valid, valid held high afterwards.
        startPulse(3);
        el = '{$urandom, $urandom, $urandom};
        runStream(el, 1, 1'b1, 1'b0, 1'b0);
        readAll();

        // Read collides with the final word1 write; out-of-range read.
        startPulse(4);
        el = '{$urandom, $urandom, $urandom, $urandom};
        runStream(el, 0, 1'b0, 1'b0, 1'b1);
        doRead(32'h10000, 64'h0, "oor_0x10000");

        // Reset mid-run, then a fresh two-element run.
        startPulse(6);
        validIn = 1'b1;
        dataIn  = $urandom;
        @(posedge clkIn); #1;
        dataIn = $urandom;
        @(posedge clkIn); #1;
        check("countBeforeReset", countOut, 2);
        rstIn = 1'b1;
        #1;
        checkResetOutputs("midRunReset");
        validIn = 1'b0;
        @(posedge clkIn); #1;
        rstIn = 1'b0;
        startPulse(2);
        el = '{$urandom, $urandom};
        runStream(el, 0, 1'b0, 1'b0, 1'b0);
        readAll();

        // Random runs, some with a start pulse injected mid-collect.
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 9);
            el = {};
            for (int i = 0; i < n; i++) el.push_back($urandom);
            startPulse(n);
            runStream(el, 2, 1'($urandom_range(0, 1)), (n > 2) && ($urandom_range(0, 1) == 1), 1'b0);
            readAll();
        end

        for (int g = 0; g < 20 && expQ.size() != 0; g++) @(posedge clkIn);
        if (expQ.size() != 0) begin
            nChecks++;
            $display("FAIL drain: %0d reads still outstanding, required 0", expQ.size());
        end
        @(posedge clkIn); #1;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/cnn_result_reader.md
CNN_RESULT_READER -- requirements
Module: cnn_result_reader

Interface
REQ-001 Parameter BUS_ADDR_WIDTH, default 32, RISC-V bus address width.
REQ-002 Parameter BUS_DATA_WIDTH, default 64, RISC-V bus read data width.
REQ-003 Parameter DATA_WIDTH, default 32, result element width (FRAC_WIDTH+EXP_WIDTH single precision).
REQ-004 Parameter MAX_SIZE, default 4096, maximum result elements per run.
REQ-005 One clock; reset is asynchronous and active-high; ports are clkIn and rstIn.
REQ-006 clkIn  input  1  clock.
REQ-007 rstIn  input  1  asynchronous active-high reset.
REQ-008 startIn  input  1  single-cycle pulse arming a new collection run.
REQ-009 numResultsIn  input  $clog2(MAX_SIZE)+1  element count for the run, sampled on startIn.
REQ-010 dataIn  input  DATA_WIDTH  result element from the accelerator output FIFO.
REQ-011 validIn  input  1  dataIn valid.
REQ-012 readyOut  output  1  element accepted when validIn and readyOut are both high.
REQ-013 addrIn  input  BUS_ADDR_WIDTH  bus byte address.
REQ-014 rdEnIn  input  1  bus read request.
REQ-015 rdDataOut  output  BUS_DATA_WIDTH  bus read data.
REQ-016 rdAckOut  output  1  read data valid.
REQ-017 busyOut, doneOut, errOut  output  1 each  run in progress, run complete, illegal start.
REQ-018 countOut  output  $clog2(MAX_SIZE)+1  elements accepted in the current or last run.

Function
REQ-019 States are IDLE, COLLECT and DONE; busyOut is high only in COLLECT, and doneOut is high only in DONE.
REQ-020 In IDLE or DONE, startIn with 1 <= numResultsIn <= MAX_SIZE shall clear countOut, pointers and errOut, then enter COLLECT; readyOut rises on the next edge.
REQ-021 startIn with numResultsIn == 0 or > MAX_SIZE shall set errOut (sticky until the next legal start), leave the state unchanged, and write no data.
REQ-022 startIn in COLLECT shall be ignored.
REQ-023 readyOut is registered; it is high in COLLECT and cleared on the edge that accepts element numResultsIn-1, so no element beyond the count is accepted.
REQ-024 Element k shall be stored in RAM word k>>1, lane k[0]; lane 0 is bits 31:0 and lane 1 is bits 63:32, matching the accelerator's write packing.
REQ-025 Even elements are held in a pack register; an odd element writes the full 64-bit word in the cycle after acceptance.
REQ-026 If numResultsIn is odd, the final word shall be written with lane 1 equal to zero.
REQ-027 COLLECT shall move to DONE on the edge after the final RAM write.
REQ-028 countOut increments by one per accepted element.
REQ-029 validIn gaps of any length shall stall the run without data loss.
REQ-030 A bus read is served in any state: rdEnIn at cycle t gives rdAckOut=1 and rdDataOut at t+1, one cycle wide.
REQ-031 Word index = addrIn[$clog2(MAX_SIZE/2)+2:3]; addrIn bits 2:0 are ignored.
REQ-032 A read with any set address bit above the word index field returns zero with ack.
REQ-033 A read and a write to the same word in the same cycle return the old contents (read-first).
REQ-034 RAM contents persist across runs; words beyond the new run's count keep their stale values.

Reset
REQ-035 On rstIn high, without waiting for clkIn: state=IDLE, readyOut=0, busyOut=0, doneOut=0, errOut=0, countOut=0, rdAckOut=0, rdDataOut=0, pack register cleared.
REQ-036 RAM contents are not reset.
REQ-037 Reset during COLLECT aborts the run; no partial word write completes after rstIn is asserted.

Structure
REQ-038 The shared package cnn_accel_pkg holds BUS_ADDR_WIDTH, BUS_DATA_WIDTH, DATA_WIDTH, MAX_SIZE and the IDLE/COLLECT/DONE state encoding.
REQ-039 Result storage is one instance of the existing sp_ram sub-module: depth MAX_SIZE/2, 64-bit wide, one-cycle read latency.

Verification
REQ-040 numResultsIn=4, elements 0x3F800000..0x40800000 streamed back-to-back -> word0={0x40000000,0x3F800000}, word1={0x40800000,0x40400000}, doneOut on the 2nd edge after the last beat, countOut=4.
REQ-041 numResultsIn=3, validIn toggled every other cycle -> 3 accepts, word1 lane1=0, readyOut low after the 3rd accept even with validIn held high.
REQ-042 startIn with numResultsIn=0, then with 4097 -> errOut=1 both times, state IDLE, readyOut stays 0; next legal start clears errOut.
REQ-043 rdEnIn with addrIn=0x8 during COLLECT, same cycle as the word1 write -> old word1 data, ack at t+1; addrIn=0x10000 -> zero with ack.
REQ-044 rstIn asserted after 2 of 6 elements -> all outputs reach reset values immediately; a new start with 2 elements completes normally.
REQ-045 startIn pulsed mid-COLLECT -> ignored; countOut and the run continue unchanged.
